data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 512: number of 64-bit storage words.
REQ-002 Parameter BASE_ADDR, default 64'h0: byte address of word 0.
REQ-003 Parameter READ_LATENCY, default 2, legal 1..15: cycles from read acceptance to read_ready.
REQ-004 Parameter WRITE_LATENCY, default 3, legal 1..15: cycles from write acceptance to write_finished.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 read_request  input  1  level; initiator holds high until read_ready is seen.
REQ-008 write_request  input  1  level; initiator holds high until write_finished is seen.
REQ-009 address  input  64  byte address of the access.
REQ-010 block_size  input  2  access size: 2'b11 = 8 B, 2'b00 = 4 B, 2'b01 = 2 B, 2'b10 = 1 B.
REQ-011 write_data  input  64  store data, right-justified (bits [8*N-1:0] used).
REQ-012 read_data  output  64  load data, zero-extended, right-justified.
REQ-013 read_ready  output  1  read complete; read_data valid while high.
REQ-014 write_ready  output  1  high only in IDLE; responder can accept a request.
REQ-015 write_finished  output  1  write committed.
REQ-016 access_error  output  1  valid with read_ready/write_finished; flags misaligned or out-of-range access.

Function
REQ-017 FSM states SHALL be IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
REQ-018 In IDLE, read_request high SHALL latch address/block_size and enter RD_WAIT; read has priority when both requests are high.
REQ-019 In IDLE, write_request high with read_request low SHALL latch address/block_size/write_data and enter WR_WAIT.
REQ-020 Inputs SHALL be ignored outside IDLE; only latched values are used.
REQ-021 A 4-bit counter SHALL load LATENCY-1 on acceptance and decrement each cycle; the WAIT->DONE transition occurs at count 0, so a request accepted at edge N asserts read_ready/write_finished after edge N+LATENCY.
REQ-022 Byte offset = address - BASE_ADDR, word index = offset[..:3], lane = offset[2:0]; little-endian byte lanes.
REQ-023 An access is misaligned if lane is not a multiple of its size; out-of-range if offset >= DEPTH_WORDS*8 or address < BASE_ADDR (64-bit compare, no wrap).
REQ-024 Write SHALL update only the N addressed bytes, on the WR_WAIT->WR_DONE edge; the other bytes of the word are unchanged.
REQ-025 Read SHALL register data on the RD_WAIT->RD_DONE edge and hold read_data stable throughout RD_DONE.
REQ-026 An erroneous access SHALL assert access_error, write no bytes, and return read_data = 0; the handshake completes normally.
REQ-027 RD_DONE/WR_DONE SHALL hold read_ready/write_finished high until the corresponding request is sampled low, then return to IDLE. Minimum assertion is one cycle.
REQ-028 A request dropped during WAIT SHALL still complete: the write commits, and the DONE state lasts exactly one cycle.
REQ-029 A new request SHALL be accepted no earlier than the first edge in IDLE, so there is at least one idle cycle between transactions.
REQ-030 read_ready, write_finished and access_error SHALL be low in all other states; read_data holds its last value outside RD_DONE.

Reset
REQ-031 rst_n low SHALL force IDLE asynchronously: read_ready = 0, write_finished = 0, access_error = 0, read_data = 0, counter = 0, write_ready = 1 after release.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset during WR_WAIT SHALL abort the write with no bytes modified; reset during RD_WAIT discards the read.

Verification
REQ-034 Write 8 B 64'hdeadbeefdeadbeef @0x00, read 8 B @0x00 -> read_data = 64'hdeadbeefdeadbeef; write_finished asserts 3 cycles and read_ready 2 cycles after acceptance.
REQ-035 Write 1 B 8'haa @0x38, 8'hbb @0x39, 2 B 16'hcab0 @0x3a, 4 B 32'hf00dfeed @0x3c; read 8 B @0x38 -> 64'hf00dfeedcab0bbaa; read 1 B @0x39 -> 64'hbb.
REQ-036 Write 4 B @0x22 (misaligned), then write 8 B @DEPTH_WORDS*8 -> access_error = 1 with write_finished for each; memory at 0x20 unchanged; read returns 0 with access_error.
REQ-037 read_request and write_request raised on the same edge -> read is serviced first; write accepted only after read_request drops and one IDLE cycle elapses.
REQ-038 Assert rst_n low mid-WR_WAIT on a write of 64'h1 @0x08 -> outputs go to their reset values immediately; a subsequent read @0x08 returns the prior value.
REQ-039 Drop write_request one cycle after acceptance -> write still commits, and write_finished is high for exactly one cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data memory responder: 64-bit word store answering single read/write
// requests with a level handshake and fixed, parameterised latencies.
// Accesses of 1/2/4/8 bytes use little-endian byte lanes; misaligned or
// out-of-range accesses complete normally but flag access_error.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS   = 512,
    parameter logic [63:0] BASE_ADDR     = 64'h0,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_request,
    input  logic        write_request,
    input  logic [63:0] address,
    input  logic [1:0]  block_size,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        read_ready,
    output logic        write_ready,
    output logic        write_finished,
    output logic        access_error
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  RD_LOAD   = 4'(READ_LATENCY - 1);
    localparam logic [3:0]  WR_LOAD   = 4'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_wdata;
    logic [63:0] r_read_data;
    logic        r_read_ready;
    logic        r_write_ready;
    logic        r_write_finished;
    logic        r_access_error;

    logic [63:0] r_mem [DEPTH_WORDS];

    logic [63:0]      w_offset;
    logic [2:0]       w_lane;
    logic [IDX_W-1:0] w_index;
    logic [7:0]       w_size_mask;
    logic [63:0]      w_rd_mask;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_error;
    logic [7:0]       w_byte_en;
    logic [63:0]      w_wdata_lanes;
    logic [63:0]      w_rd_word;
    logic [63:0]      w_rd_value;
    logic             w_commit;

    // Address decode works only on the latched request, never on live inputs.
    assign w_offset       = r_addr - BASE_ADDR;
    assign w_lane         = w_offset[2:0];
    assign w_index        = w_offset[IDX_W+2:3];
    assign w_out_of_range = (r_addr < BASE_ADDR) || (w_offset >= MEM_BYTES);
    assign w_error        = w_misaligned || w_out_of_range;

    // Per-size byte mask, load mask and alignment rule.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_size_mask  = 8'h01;
        w_rd_mask    = 64'h0000_0000_0000_00ff;
        w_misaligned = 1'b0;
        case (r_size)
            2'b11: begin
                w_size_mask  = 8'hff;
                w_rd_mask    = 64'hffff_ffff_ffff_ffff;
                w_misaligned = (w_lane != 3'd0);
            end
            2'b00: begin
                w_size_mask  = 8'h0f;
                w_rd_mask    = 64'h0000_0000_ffff_ffff;
                w_misaligned = (w_lane[1:0] != 2'd0);
            end
            2'b01: begin
                w_size_mask  = 8'h03;
                w_rd_mask    = 64'h0000_0000_0000_ffff;
                w_misaligned = w_lane[0];
            end
            default: begin
                w_size_mask  = 8'h01;
                w_rd_mask    = 64'h0000_0000_0000_00ff;
                w_misaligned = 1'b0;
            end
        endcase
    end

    assign w_byte_en     = w_size_mask << w_lane;
    assign w_wdata_lanes = r_wdata << {w_lane, 3'b000};
    assign w_rd_word     = r_mem[w_index];
    assign w_rd_value    = w_error ? 64'h0 : ((w_rd_word >> {w_lane, 3'b000}) & w_rd_mask);
    assign w_commit      = (r_state == WR_WAIT) && (r_count == 4'd0) && !w_error;

    // Handshake FSM with latency counter and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_count          <= 4'd0;
            r_addr           <= 64'h0;
            r_size           <= 2'b00;
            r_wdata          <= 64'h0;
            r_read_data      <= 64'h0;
            r_read_ready     <= 1'b0;
            r_write_ready    <= 1'b1;
            r_write_finished <= 1'b0;
            r_access_error   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (read_request) begin
                        r_addr        <= address;
                        r_size        <= block_size;
                        r_count       <= RD_LOAD;
                        r_write_ready <= 1'b0;
                        r_state       <= RD_WAIT;
                    end else if (write_request) begin
                        r_addr        <= address;
                        r_size        <= block_size;
                        r_wdata       <= write_data;
                        r_count       <= WR_LOAD;
                        r_write_ready <= 1'b0;
                        r_state       <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_read_data    <= w_rd_value;
                        r_read_ready   <= 1'b1;
                        r_access_error <= w_error;
                        r_state        <= RD_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RD_DONE: begin
                    if (!read_request) begin
                        r_read_ready   <= 1'b0;
                        r_access_error <= 1'b0;
                        r_write_ready  <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_write_finished <= 1'b1;
                        r_access_error   <= w_error;
                        r_state          <= WR_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                WR_DONE: begin
                    if (!write_request) begin
                        r_write_finished <= 1'b0;
                        r_access_error   <= 1'b0;
                        r_write_ready    <= 1'b1;
                        r_state          <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked store, committed on the WR_WAIT->WR_DONE edge.
    // NOTE: storage has no reset; contents survive rst_n and an aborted write never reaches here.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    assign read_data      = r_read_data;
    assign read_ready     = r_read_ready;
    assign write_ready    = r_write_ready;
    assign write_finished = r_write_finished;
    assign access_error   = r_access_error;

endmodule
